// File: rtl/load_store_unit.sv
// Load/store initiator for the byte-lane memory port: one request at a time,
// word-aligned beats with byte strobes, split across word boundaries, extended load results.
module load_store_unit #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(32'h1FC)
) (
  input  logic              iwClk,
  input  logic              iwRst,
  input  logic              iwReqValid,
  output logic              owReqReady,
  input  logic              iwReqWrite,
  input  logic [1:0]        iwReqSize,
  input  logic              iwReqSigned,
  input  logic [ADDR_W-1:0] iwReqAddr,
  input  logic [31:0]       iwReqData,
  output logic              owRespValid,
  input  logic              iwRespReady,
  output logic [31:0]       owRespData,
  output logic              owRespErr,
  output logic [ADDR_W-1:0] owMemAddr,
  output logic [31:0]       owMemWriteData,
  output logic [3:0]        owMemWstrb,
  input  logic [31:0]       iwMemReadData
);

  localparam int unsigned       AW1       = ADDR_W + 1;
  localparam logic [ADDR_W:0]   LAST_BYTE = AW1'(LAST_ADDR) + AW1'(3);

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_e;

  state_e              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [31:0]         resp_data_q, resp_data_d;
  logic                resp_err_q, resp_err_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_wstrb_q, mem_wstrb_d;
  logic [31:0]         gather_q, gather_d;
  logic                write_q, write_d;
  logic [1:0]          size_q, size_d;
  logic                signed_q, signed_d;
  logic [1:0]          off_q, off_d;
  logic                split_q, split_d;
  logic [3:0]          mask_q, mask_d;
  logic [31:0]         data_q, data_d;

  logic [2:0]          req_bytes;
  logic [3:0]          req_mask;
  logic [ADDR_W:0]     req_end;
  logic                req_err;
  logic                req_split;
  logic                accept;
  logic [2:0]          hi_off;

  function automatic logic [31:0] extend_load(input logic [31:0] g, input logic [1:0] sz,
                                              input logic sg);
    case (sz)
      2'd0:    extend_load = {{24{sg & g[7]}}, g[7:0]};
      2'd1:    extend_load = {{16{sg & g[15]}}, g[15:0]};
      default: extend_load = g;
    endcase
  endfunction

  // Request decode: byte count, lane mask, range check (widened so a wrap exceeds LAST_BYTE)
  always_comb begin
    req_bytes = 3'd4;
    req_mask  = 4'b1111;
    case (iwReqSize)
      2'd0:    begin req_bytes = 3'd1; req_mask = 4'b0001; end
      2'd1:    begin req_bytes = 3'd2; req_mask = 4'b0011; end
      default: begin req_bytes = 3'd4; req_mask = 4'b1111; end
    endcase
    req_end   = {1'b0, iwReqAddr} + AW1'(req_bytes) - AW1'(1);
    req_err   = (iwReqSize == 2'd3) || (req_end > LAST_BYTE);
    req_split = ({1'b0, iwReqAddr[1:0]} + req_bytes) > 3'd4;
  end

  assign accept = iwReqValid & req_ready_q;
  assign hi_off = 3'd4 - {1'b0, off_q};

  always_comb begin
    state_d      = state_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wstrb_d  = 4'b0000;
    gather_d     = gather_q;
    write_d      = write_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    split_d      = split_q;
    mask_d       = mask_q;
    data_d       = data_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          write_d  = iwReqWrite;
          size_d   = iwReqSize;
          signed_d = iwReqSigned;
          off_d    = iwReqAddr[1:0];
          split_d  = req_split;
          mask_d   = req_mask;
          data_d   = iwReqData;
          if (req_err) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end else begin
            state_d    = S_BEAT0;
            resp_err_d = 1'b0;
            gather_d   = '0;
            mem_addr_d = {iwReqAddr[ADDR_W-1:2], 2'b00};
            if (iwReqWrite) begin
              mem_wstrb_d = req_mask << iwReqAddr[1:0];
              mem_wdata_d = iwReqData << {iwReqAddr[1:0], 3'b000};
            end
          end
        end
      end
      S_BEAT0: begin
        if (!write_q) begin
          gather_d = iwMemReadData >> {off_q, 3'b000};
        end
        if (split_q) begin
          state_d    = S_BEAT1;
          mem_addr_d = mem_addr_q + ADDR_W'(4);
          if (write_q) begin
            mem_wstrb_d = mask_q >> hi_off;
            mem_wdata_d = data_q >> {hi_off, 3'b000};
          end
        end else begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_data_d  = write_q ? 32'd0 : extend_load(gather_d, size_q, signed_q);
        end
      end
      S_BEAT1: begin
        if (!write_q) begin
          gather_d = gather_q | (iwMemReadData << {hi_off, 3'b000});
        end
        state_d      = S_RESP;
        resp_valid_d = 1'b1;
        resp_data_d  = write_q ? 32'd0 : extend_load(gather_d, size_q, signed_q);
      end
      S_RESP: begin
        if (iwRespReady) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // One idle turnaround cycle after a response before the next request is taken
    req_ready_d = (state_q == S_IDLE) && (state_d == S_IDLE);
  end

  always_ff @(posedge iwClk or posedge iwRst) begin
    if (iwRst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wstrb_q  <= '0;
      gather_q     <= '0;
      write_q      <= 1'b0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      off_q        <= '0;
      split_q      <= 1'b0;
      mask_q       <= '0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wstrb_q  <= mem_wstrb_d;
      gather_q     <= gather_d;
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      split_q      <= split_d;
      mask_q       <= mask_d;
      data_q       <= data_d;
    end
  end

  assign owReqReady     = req_ready_q;
  assign owRespValid    = resp_valid_q;
  assign owRespData     = resp_data_q;
  assign owRespErr      = resp_err_q;
  assign owMemAddr      = mem_addr_q;
  assign owMemWriteData = mem_wdata_q;
  assign owMemWstrb     = mem_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table over a byte-array memory model,
// plus hand sequences for beat traces, ready timing, response hold and mid-split reset.
module tb_load_store_unit;

  localparam int unsigned ADDR_W = 32;

  logic              iwClk = 1'b0;
  logic              iwRst;
  logic              iwReqValid;
  logic              owReqReady;
  logic              iwReqWrite;
  logic [1:0]        iwReqSize;
  logic              iwReqSigned;
  logic [ADDR_W-1:0] iwReqAddr;
  logic [31:0]       iwReqData;
  logic              owRespValid;
  logic              iwRespReady;
  logic [31:0]       owRespData;
  logic              owRespErr;
  logic [ADDR_W-1:0] owMemAddr;
  logic [31:0]       owMemWriteData;
  logic [3:0]        owMemWstrb;
  logic [31:0]       iwMemReadData;

  always #5 iwClk = ~iwClk;

  load_store_unit #(.ADDR_W(ADDR_W), .LAST_ADDR(32'h1FC)) dut (
    .iwClk(iwClk), .iwRst(iwRst),
    .iwReqValid(iwReqValid), .owReqReady(owReqReady), .iwReqWrite(iwReqWrite),
    .iwReqSize(iwReqSize), .iwReqSigned(iwReqSigned), .iwReqAddr(iwReqAddr),
    .iwReqData(iwReqData), .owRespValid(owRespValid), .iwRespReady(iwRespReady),
    .owRespData(owRespData), .owRespErr(owRespErr), .owMemAddr(owMemAddr),
    .owMemWriteData(owMemWriteData), .owMemWstrb(owMemWstrb), .iwMemReadData(iwMemReadData)
  );

  // 512-byte memory behind the port
  logic [7:0] mem [0:511];
  logic       mem_clr;

  always_comb begin
    iwMemReadData = '0;
    if (owMemAddr[31:9] == '0)
      for (int b = 0; b < 4; b++) iwMemReadData[8*b +: 8] = mem[{owMemAddr[8:2], 2'(b)}];
  end

  always @(posedge iwClk) begin
    if (mem_clr) begin
      for (int i = 0; i < 512; i++) mem[i] <= 8'h00;
    end else if (owMemAddr[31:9] == '0) begin
      for (int b = 0; b < 4; b++)
        if (owMemWstrb[b]) mem[{owMemAddr[8:2], 2'(b)}] <= owMemWriteData[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Beat trace recorded by do_req
  int          n_beats;
  logic [31:0] beat_addr [2];
  logic [3:0]  beat_strb [2];
  logic [31:0] beat_data [2];

  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] data,
                        output logic [31:0] rdata, output logic rerr, output int lat);
    n_beats = 0;
    @(negedge iwClk);
    check("req_ready_idle", 32'(owReqReady), 32'd1);
    iwReqValid = 1'b1; iwReqWrite = wr; iwReqSize = sz; iwReqSigned = sg;
    iwReqAddr = addr; iwReqData = data;
    @(negedge iwClk);
    iwReqValid = 1'b0; iwReqWrite = ~wr; iwReqSize = 2'd3; iwReqSigned = ~sg;
    iwReqAddr = 32'hFFFF_FFFF; iwReqData = 32'h5A5A_5A5A;
    lat = 1;
    forever begin
      if (owMemWstrb != 4'b0000) begin
        if (n_beats < 2) begin
          beat_addr[n_beats] = owMemAddr;
          beat_strb[n_beats] = owMemWstrb;
          beat_data[n_beats] = owMemWriteData;
        end
        n_beats++;
      end
      if (owRespValid || lat >= 10) break;
      @(negedge iwClk);
      lat++;
    end
    if (!owRespValid) check("resp_timeout", 32'(owRespValid), 32'd1);
    rdata = owRespData;
    rerr  = owRespErr;
    iwRespReady = 1'b1;
    @(negedge iwClk);
    iwRespReady = 1'b0;
    check("resp_valid_drop", 32'(owRespValid), 32'd0);
  endtask

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
    int          exp_beats;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;
    logic        re;
    int          lat;
    int          cnt;
    logic [31:0] held;

    // Memory starts all zero; later loads see earlier stores
    vecs[0]  = '{1'b1, 2'd2, 1'b0, 32'h10,  32'hDEADBEEF, 32'h0,        1'b0, 2, 1};
    vecs[1]  = '{1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, 0};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 32'h13,  32'h80,       32'h0,        1'b0, 2, 1};
    vecs[3]  = '{1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0, 2, 0};
    vecs[4]  = '{1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'h00000080, 1'b0, 2, 0};
    vecs[5]  = '{1'b0, 2'd1, 1'b1, 32'h12,  32'h0,        32'hFFFF80AD, 1'b0, 2, 0};
    vecs[6]  = '{1'b1, 2'd2, 1'b0, 32'h1E,  32'h11223344, 32'h0,        1'b0, 3, 2};
    vecs[7]  = '{1'b0, 2'd2, 1'b0, 32'h1E,  32'h0,        32'h11223344, 1'b0, 3, 0};
    vecs[8]  = '{1'b1, 2'd0, 1'b0, 32'h23,  32'h34,       32'h0,        1'b0, 2, 1};
    vecs[9]  = '{1'b1, 2'd0, 1'b0, 32'h24,  32'hF2,       32'h0,        1'b0, 2, 1};
    vecs[10] = '{1'b0, 2'd1, 1'b1, 32'h23,  32'h0,        32'hFFFFF234, 1'b0, 3, 0};
    vecs[11] = '{1'b0, 2'd1, 1'b0, 32'h23,  32'h0,        32'h0000F234, 1'b0, 3, 0};
    vecs[12] = '{1'b1, 2'd3, 1'b0, 32'h0,   32'h12345678, 32'h0,        1'b1, 1, 0};
    vecs[13] = '{1'b0, 2'd2, 1'b0, 32'h1FE, 32'h0,        32'h0,        1'b1, 1, 0};
    vecs[14] = '{1'b1, 2'd2, 1'b0, 32'h1FC, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1};
    vecs[15] = '{1'b0, 2'd2, 1'b1, 32'h1FC, 32'h0,        32'hCAFEF00D, 1'b0, 2, 0};
    vecs[16] = '{1'b1, 2'd1, 1'b0, 32'h1FF, 32'hBEEF,     32'h0,        1'b1, 1, 0};
    vecs[17] = '{1'b0, 2'd1, 1'b0, 32'hFFFFFFFF, 32'h0,   32'h0,        1'b1, 1, 0};
    vecs[18] = '{1'b0, 2'd0, 1'b1, 32'h1FF, 32'h0,        32'hFFFFFFCA, 1'b0, 2, 0};
    vecs[19] = '{1'b0, 2'd1, 1'b0, 32'h21,  32'h0,        32'h00000011, 1'b0, 2, 0};

    iwRst = 1'b1; mem_clr = 1'b1;
    iwReqValid = 1'b0; iwReqWrite = 1'b0; iwReqSize = 2'd0; iwReqSigned = 1'b0;
    iwReqAddr = '0; iwReqData = '0; iwRespReady = 1'b0;
    repeat (2) @(negedge iwClk);
    check("rst_ready", 32'(owReqReady), 32'd1);
    check("rst_valid", 32'(owRespValid), 32'd0);
    check("rst_data",  owRespData, 32'd0);
    check("rst_err",   32'(owRespErr), 32'd0);
    check("rst_addr",  owMemAddr, 32'd0);
    check("rst_wdata", owMemWriteData, 32'd0);
    check("rst_wstrb", 32'(owMemWstrb), 32'd0);
    mem_clr = 1'b0;
    iwRst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].addr, vecs[i].data, rd, re, lat);
      check($sformatf("v%0d_data", i),  rd, vecs[i].exp_data);
      check($sformatf("v%0d_err", i),   32'(re), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_lat", i),   32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("v%0d_beats", i), 32'(n_beats), 32'(vecs[i].exp_beats));
    end

    // Beat contents of aligned, byte and split stores
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, rd, re, lat);
    check("word_st_addr", beat_addr[0], 32'h10);
    check("word_st_strb", 32'(beat_strb[0]), 32'hF);
    check("word_st_data", beat_data[0], 32'hDEADBEEF);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h80, rd, re, lat);
    check("byte_st_addr", beat_addr[0], 32'h10);
    check("byte_st_strb", 32'(beat_strb[0]), 32'h8);
    check("byte_st_data", beat_data[0], 32'h80000000);
    do_req(1'b1, 2'd2, 1'b0, 32'h1E, 32'h11223344, rd, re, lat);
    check("split_beats",  32'(n_beats), 32'd2);
    check("split_b0_addr", beat_addr[0], 32'h1C);
    check("split_b0_strb", 32'(beat_strb[0]), 32'hC);
    check("split_b0_data", beat_data[0], 32'h33440000);
    check("split_b1_addr", beat_addr[1], 32'h20);
    check("split_b1_strb", 32'(beat_strb[1]), 32'h3);
    check("split_b1_data", beat_data[1], 32'h00001122);

    // Split half load with iwRespReady held high: ready low for 4 cycles
    @(negedge iwClk);
    iwRespReady = 1'b1;
    iwReqValid = 1'b1; iwReqWrite = 1'b0; iwReqSize = 2'd1; iwReqSigned = 1'b1; iwReqAddr = 32'h23;
    @(negedge iwClk);
    iwReqValid = 1'b0;
    cnt = 0; held = 32'hXXXX_XXXX;
    while (!owReqReady && cnt < 20) begin
      if (owRespValid) held = owRespData;
      cnt++;
      @(negedge iwClk);
    end
    iwRespReady = 1'b0;
    check("ready_low_cycles", 32'(cnt), 32'd4);
    check("split_half_data", held, 32'hFFFFF234);

    // Response held for 5 cycles while a competing request is presented
    @(negedge iwClk);
    iwReqValid = 1'b1; iwReqWrite = 1'b0; iwReqSize = 2'd2; iwReqSigned = 1'b0; iwReqAddr = 32'h10;
    @(negedge iwClk);
    iwReqWrite = 1'b1; iwReqAddr = 32'h0; iwReqData = 32'hFFFF_FFFF;
    cnt = 0;
    while (!owRespValid && cnt < 10) begin cnt++; @(negedge iwClk); end
    check("hold_valid_seen", 32'(owRespValid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge iwClk);
      check($sformatf("hold%0d_valid", k), 32'(owRespValid), 32'd1);
      check($sformatf("hold%0d_data", k), owRespData, 32'h80ADBEEF);
      check($sformatf("hold%0d_ready", k), 32'(owReqReady), 32'd0);
      check($sformatf("hold%0d_wstrb", k), 32'(owMemWstrb), 32'd0);
    end
    iwReqValid = 1'b0; iwRespReady = 1'b1;
    @(negedge iwClk);
    iwRespReady = 1'b0;
    check("hold_release", 32'(owRespValid), 32'd0);

    // Reset asserted during BEAT1 of a split store
    @(negedge iwClk);
    iwReqValid = 1'b1; iwReqWrite = 1'b1; iwReqSize = 2'd2; iwReqAddr = 32'h3E; iwReqData = 32'hA5A5A5A5;
    @(negedge iwClk);
    iwReqValid = 1'b0;
    @(negedge iwClk);
    check("rb1_strb", 32'(owMemWstrb), 32'h3);
    check("rb1_addr", owMemAddr, 32'h40);
    #1 iwRst = 1'b1;
    #1;
    check("arst_ready", 32'(owReqReady), 32'd1);
    check("arst_valid", 32'(owRespValid), 32'd0);
    check("arst_data",  owRespData, 32'd0);
    check("arst_err",   32'(owRespErr), 32'd0);
    check("arst_addr",  owMemAddr, 32'd0);
    check("arst_wdata", owMemWriteData, 32'd0);
    check("arst_wstrb", 32'(owMemWstrb), 32'd0);
    @(negedge iwClk);
    iwRst = 1'b0;
    @(negedge iwClk);
    check("post_rst_ready", 32'(owReqReady), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h1E, 32'h0, rd, re, lat);
    check("post_rst_data", rd, 32'h11223344);
    check("post_rst_lat",  32'(lat), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
